// File: rtl/regfile_pkg.sv
// Shared register-file parameters and writeback types.
// Used by the writeback arbiter and the register file itself.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     we;
    reg_idx_t rd;
    word_t    data;
  } wb_t;

  // x0 is hardwired to zero, so it never takes a write.
  function automatic logic writes_reg(reg_idx_t rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant selector with a last-grant pointer.
// On conflict the requester other than ptr_i wins.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  // One-hot grant from requests and pointer.
  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: ALU (req0) vs load unit (req1) into the regfile.
// REGFILE_WB_RR_FAIR_EN selects round-robin; default is req0 priority.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [REG_ADDR_W-1:0] req0_rd,
  input  logic [XLEN-1:0]       req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [REG_ADDR_W-1:0] req1_rd,
  input  logic [XLEN-1:0]       req1_data,
  output logic                  req1_ready,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] Rd,
  output logic [XLEN-1:0]       Write_data,
  output logic                  last_grant
);

  logic [1:0] req;
  logic [1:0] gnt;
  logic       ptr;
  logic       xfer;
  reg_idx_t   sel_rd;
  word_t      sel_data;

  wb_t  wb_q;
  wb_t  wb_d;
  logic lg_q;
  logic lg_d;

  assign req = {req1_valid, req0_valid};

`ifdef REGFILE_WB_RR_FAIR_EN
  assign ptr = lg_q;
`else
  // Pointer pinned at 1 makes req0 win every conflict.
  assign ptr = 1'b1;
`endif

  rr_arbiter2 u_arb (
    .req_i (req),
    .ptr_i (ptr),
    .gnt_o (gnt)
  );

  assign req0_ready = gnt[0] & ~rst;
  assign req1_ready = gnt[1] & ~rst;
  assign xfer       = req0_ready | req1_ready;
  assign sel_rd     = req1_ready ? req1_rd : req0_rd;
  assign sel_data   = req1_ready ? req1_data : req0_data;

  // Next writeback and pointer; rd/data hold unless a real write.
  always_comb begin
    wb_d    = wb_q;
    wb_d.we = 1'b0;
    lg_d    = lg_q;
    if (xfer) begin
      lg_d = req1_ready;
      if (writes_reg(sel_rd)) begin
        wb_d.we   = 1'b1;
        wb_d.rd   = sel_rd;
        wb_d.data = sel_data;
      end
    end
  end

  // Output register and last-grant pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= '0;
      lg_q <= 1'b1;
    end else begin
      wb_q <= wb_d;
      lg_q <= lg_d;
    end
  end

  assign RegWrite   = wb_q.we;
  assign Rd         = wb_q.rd;
  assign Write_data = wb_q.data;
  assign last_grant = lg_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed cases then random traffic.
// Expected writebacks are queued by the driver and checked by a monitor.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic [4:0]  req0_rd;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_rd;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        RegWrite;
  logic [4:0]  Rd;
  logic [31:0] Write_data;
  logic        last_grant;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_rd    (req0_rd),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_rd    (req1_rd),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .RegWrite   (RegWrite),
    .Rd         (Rd),
    .Write_data (Write_data),
    .last_grant (last_grant)
  );

  typedef struct {
    bit          rw;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          lg;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: what the register-file port should show.
  bit          m_last = 1'b1;
  logic [4:0]  m_rd   = '0;
  logic [31:0] m_data = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, want);
    end
  endtask

  // Drive one cycle, check grants, queue the expected writeback.
  task automatic step(input bit r,
                      input bit v0, input logic [4:0] a0,
                      input logic [31:0] d0,
                      input bit v1, input logic [4:0] a1,
                      input logic [31:0] d1,
                      output int g);
    exp_t e;
    @(negedge clk);
    rst = r;
    req0_valid = v0; req0_rd = a0; req0_data = d0;
    req1_valid = v1; req1_rd = a1; req1_data = d1;
    #1;
    g = -1;
    if (!r) begin
      if (v0 && v1) begin
`ifdef REGFILE_WB_RR_FAIR_EN
        g = (m_last == 1'b0) ? 1 : 0;
`else
        g = 0;
`endif
      end else if (v0) g = 0;
      else if (v1) g = 1;
    end
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
    e.rw = 1'b0;
    if (r) begin
      m_last = 1'b1; m_rd = '0; m_data = '0;
    end else if (g >= 0) begin
      m_last = (g == 1);
      if (((g == 0) ? a0 : a1) != 5'd0) begin
        e.rw   = 1'b1;
        m_rd   = (g == 0) ? a0 : a1;
        m_data = (g == 0) ? d0 : d1;
      end
    end
    e.rd = m_rd; e.data = m_data; e.lg = m_last;
    exp_q.push_back(e);
  endtask

  task automatic idle(input bit r);
    int g;
    step(r, 0, 0, 0, 0, 0, 0, g);
  endtask

  // Monitor: compare registered outputs just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("RegWrite", {31'd0, RegWrite}, {31'd0, e.rw});
        chk("Rd", {27'd0, Rd}, {27'd0, e.rd});
        chk("Write_data", Write_data, e.data);
        chk("last_grant", {31'd0, last_grant}, {31'd0, e.lg});
      end
    end
  end

  initial begin
    int g;
    bit p0, p1;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    rst = 1'b1;
    req0_valid = 0; req0_rd = 0; req0_data = 0;
    req1_valid = 0; req1_rd = 0; req1_data = 0;
    idle(1); idle(1);
    // single ALU write
    step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, g);
    idle(0); idle(0);
    // sustained conflict
    for (int i = 0; i < 4; i++)
      step(0, 1, 5'd1, 32'hA0A0_0001, 1, 5'd2, 32'hB0B0_0002, g);
    idle(0);
    // x0 write is accepted but dropped
    step(0, 0, 0, 0, 1, 5'd0, 32'h0000_1234, g);
    idle(0);
    // reset right after a transfer
    step(0, 1, 5'd7, 32'h7777_7777, 0, 0, 0, g);
    idle(1);
    idle(0);
    // req0 alone, then conflict
    for (int i = 0; i < 3; i++)
      step(0, 1, 5'd3 + 5'(i), 32'h3000 + i, 0, 0, 0, g);
    step(0, 1, 5'd9, 32'h9999, 1, 5'd10, 32'h1010, g);
    idle(0); idle(0); idle(0);
    // random traffic, requests held until granted
    p0 = 0; p1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1;
        a0 = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        d0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1;
        a1 = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        d1 = $urandom;
      end
      step($urandom_range(0, 39) == 0, p0, a0, d0, p1, a1, d1, g);
      if (g == 0) p0 = 0;
      if (g == 1) p1 = 0;
    end
    idle(0); idle(0);
    @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
